// File: rtl/aclk_pkg.sv
// ============================================================================
// Module   : aclk_pkg
// Brief    : Shared types and constants for the alarm clock controller and display.
// Revision : 1.0
// ============================================================================
`default_nettype none

package aclk_pkg;

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    SHOW_ALARM       = 3'd1,
    KEY_STORED       = 3'd2,
    KEY_WAIT         = 3'd3,
    KEY_ENTRY        = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_e;

  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;

  // Character codes used by the LCD display driver
  localparam logic [7:0] CHAR_BLANK = 8'h20;
  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_COLON = 8'h3A;
  localparam logic [7:0] CHAR_A     = 8'h41;

  function automatic logic key_pressed(input logic [3:0] key);
    return (key <= KEY_MAX_DIGIT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aclk_timeout_cnt.sv
// ============================================================================
// Module   : aclk_timeout_cnt
// Brief    : Inactivity timer; flags the TIMEOUT_SEC-th tick since last clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aclk_timeout_cnt #(
  parameter int TIMEOUT_SEC = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic tick,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_SEC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = tick & (cnt_q == LAST_COUNT);

endmodule

`default_nettype wire

// File: rtl/aclk_controller.sv
// ============================================================================
// Module   : aclk_controller
// Brief    : Alarm clock main FSM; selects the display source and pulses loads.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aclk_controller
  import aclk_pkg::*;
#(
  parameter int TIMEOUT_SEC = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] Key,
  input  logic       Alarm_button,
  input  logic       Time_button,
  output logic       show_a,
  output logic       Show_new_time,
  output logic       Shift,
  output logic       Load_new_alarm,
  output logic       Load_new_c
);

  state_e state_q;
  state_e state_d;
  logic   pressed;
  logic   timer_clr;
  logic   timeout;

  assign pressed   = key_pressed(Key);
  // Only the two key-entry states let the inactivity timer run
  assign timer_clr = (state_q != KEY_WAIT) && (state_q != KEY_ENTRY);

  aclk_timeout_cnt #(
    .TIMEOUT_SEC (TIMEOUT_SEC),
    .CNT_W       (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr),
    .tick    (one_second),
    .expired (timeout)
  );

  always_comb begin
    state_d        = state_q;
    show_a         = 1'b0;
    Show_new_time  = 1'b0;
    Shift          = 1'b0;
    Load_new_alarm = 1'b0;
    Load_new_c     = 1'b0;
    case (state_q)
      SHOW_TIME: begin
        if (Alarm_button)  state_d = SHOW_ALARM;
        else if (pressed)  state_d = KEY_STORED;
      end
      SHOW_ALARM: begin
        show_a = 1'b1;
        if (!Alarm_button) state_d = SHOW_TIME;
      end
      KEY_STORED: begin
        Shift         = 1'b1;
        Show_new_time = 1'b1;
        state_d       = KEY_WAIT;
      end
      KEY_WAIT: begin
        Show_new_time = 1'b1;
        if (timeout)       state_d = SHOW_TIME;
        else if (!pressed) state_d = KEY_ENTRY;
      end
      KEY_ENTRY: begin
        Show_new_time = 1'b1;
        if (Alarm_button)     state_d = SET_ALARM_TIME;
        else if (Time_button) state_d = SET_CURRENT_TIME;
        else if (pressed)     state_d = KEY_STORED;
        else if (timeout)     state_d = SHOW_TIME;
      end
      SET_ALARM_TIME: begin
        Load_new_alarm = 1'b1;
        state_d        = SHOW_TIME;
      end
      SET_CURRENT_TIME: begin
        Load_new_c = 1'b1;
        state_d    = SHOW_TIME;
      end
      default: begin
        state_d = SHOW_TIME;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SHOW_TIME;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

`default_nettype wire
